// File: rtl/writeback_stage_pkg.sv
// Shared types, constants and helpers for the writeback stage.
// Load width/sign encodings, source-select enum, pending-entry layout and
// the load extraction/extension helper live here so the top and the
// pending FIFO agree on one definition.
package writeback_stage_pkg;

  localparam int WB_DATA_WIDTH     = 32;
  localparam int WB_REG_ADDR_WIDTH = 5;

  localparam logic [2:0] LB  = 3'b000;
  localparam logic [2:0] LH  = 3'b001;
  localparam logic [2:0] LW  = 3'b010;
  localparam logic [2:0] LBU = 3'b100;
  localparam logic [2:0] LHU = 3'b101;

  typedef enum logic [1:0] {
    WB_NONE,
    WB_PIPE,
    WB_PEND,
    WB_LU_BYPASS
  } wb_src_t;

  // A pending long-latency result; valid drops when a younger pipe write
  // to the same register makes the result obsolete.
  typedef struct packed {
    logic                         valid;
    logic [WB_REG_ADDR_WIDTH-1:0] rd;
    logic [WB_DATA_WIDTH-1:0]     data;
  } pend_entry_t;

  // Pick the addressed byte/half out of an aligned word and extend it.
  // Unknown encodings fall back to the whole word.
  function automatic logic [WB_DATA_WIDTH-1:0] load_extend(
    input logic [WB_DATA_WIDTH-1:0] word,
    input logic [2:0]               funct3,
    input logic [1:0]               off
  );
    logic [7:0]               byte_v;
    logic [15:0]              half_v;
    logic [WB_DATA_WIDTH-1:0] result;
    byte_v = word[{off, 3'b000} +: 8];
    half_v = off[1] ? word[31:16] : word[15:0];
    case (funct3)
      LB:      result = {{24{byte_v[7]}}, byte_v};
      LBU:     result = {24'h000000, byte_v};
      LH:      result = {{16{half_v[15]}}, half_v};
      LHU:     result = {16'h0000, half_v};
      LW:      result = word;
      default: result = word;
    endcase
    return result;
  endfunction

endpackage

// File: rtl/writeback_pend_fifo.sv
// Circular buffer holding long-latency results that could not take the
// register-file write port on arrival. Supports one push and one pop per
// cycle plus a broadcast invalidate (kill) by destination register that
// clears the valid flag of every stored entry with a matching rd.
module writeback_pend_fifo
  import writeback_stage_pkg::*;
#(
  parameter int DEPTH = 4,
  localparam int PTR_W = $clog2(DEPTH),
  localparam int CNT_W = PTR_W + 1
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         push,
  input  pend_entry_t                  push_entry,
  input  logic                         pop,
  input  logic                         kill_en,
  input  logic [WB_REG_ADDR_WIDTH-1:0] kill_id,
  output pend_entry_t                  head,
  output logic [CNT_W-1:0]             count,
  output logic                         full,
  output logic                         empty
);

  pend_entry_t      mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == CNT_W'(DEPTH));
  assign empty   = (count == '0);
  assign head    = mem[rd_ptr];
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;

  // Storage, pointers and occupancy; kill clears valid everywhere, a push
  // then overwrites its own slot, and pointers wrap naturally (DEPTH is 2^n).
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        if (kill_en && (mem[i].rd == kill_id)) begin
          mem[i].valid <= 1'b0;
        end
      end
      if (do_push) begin
        mem[wr_ptr] <= push_entry;
        wr_ptr      <= wr_ptr + 1'b1;
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/writeback_stage.sv
// Final pipeline stage: merges in-order memory-stage results and
// out-of-order long-latency results onto one registered register-file
// write port. Long-latency results that lose arbitration wait in a small
// FIFO; a younger pipe write to the same rd invalidates them.
// Optional macro WB_FORWARD_EN exposes the combinational selected source
// (fwd_valid/fwd_id/fwd_data) for same-cycle bypass in decode.
// DATA_WIDTH and REG_ADDR_WIDTH must match the package widths, since the
// pending entry layout and load helper are defined there.
module writeback_stage
  import writeback_stage_pkg::*;
#(
  parameter int DATA_WIDTH     = WB_DATA_WIDTH,
  parameter int REG_ADDR_WIDTH = WB_REG_ADDR_WIDTH,
  parameter int PEND_DEPTH     = 4
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          wb_valid,
  input  logic                          wb_reg_write,
  input  logic                          wb_mem_read,
  input  logic [2:0]                    wb_funct3,
  input  logic [REG_ADDR_WIDTH-1:0]     wb_rd_id,
  input  logic [DATA_WIDTH-1:0]         wb_alu_result,
  input  logic [DATA_WIDTH-1:0]         wb_mem_data,
  input  logic                          lu_valid,
  output logic                          lu_ready,
  input  logic [REG_ADDR_WIDTH-1:0]     lu_rd_id,
  input  logic [DATA_WIDTH-1:0]         lu_data,
  output logic                          write_en,
  output logic [REG_ADDR_WIDTH-1:0]     write_id,
  output logic [DATA_WIDTH-1:0]         write_data,
  output logic [$clog2(PEND_DEPTH):0]   pend_count
`ifdef WB_FORWARD_EN
  ,
  output logic                          fwd_valid,
  output logic [REG_ADDR_WIDTH-1:0]     fwd_id,
  output logic [DATA_WIDTH-1:0]         fwd_data
`endif
);

  logic                      pipe_write;
  logic [DATA_WIDTH-1:0]     pipe_data;
  logic                      lu_accept;
  logic                      lu_nonzero;
  logic                      fifo_empty;
  logic                      fifo_full;
  logic                      fifo_push;
  logic                      fifo_pop;
  pend_entry_t               push_entry;
  pend_entry_t               head;
  wb_src_t                   src;
  logic [REG_ADDR_WIDTH-1:0] sel_id;
  logic [DATA_WIDTH-1:0]     sel_data;

  assign pipe_write = wb_valid && wb_reg_write && (wb_rd_id != '0);
  assign pipe_data  = wb_mem_read
                      ? load_extend(wb_mem_data, wb_funct3, wb_alu_result[1:0])
                      : wb_alu_result;

  // Ready follows the registered occupancy only, so a slot freed by this
  // cycle's pop is offered to the long-latency unit one cycle later.
  assign lu_ready   = !fifo_full;
  assign lu_accept  = lu_valid && lu_ready;
  assign lu_nonzero = (lu_rd_id != '0);

  writeback_pend_fifo #(
    .DEPTH (PEND_DEPTH)
  ) u_pend_fifo (
    .clk        (clk),
    .reset      (reset),
    .push       (fifo_push),
    .push_entry (push_entry),
    .pop        (fifo_pop),
    .kill_en    (pipe_write),
    .kill_id    (wb_rd_id),
    .head       (head),
    .count      (pend_count),
    .full       (fifo_full),
    .empty      (fifo_empty)
  );

  // Arbitrate the write port: pipe first, then a valid buffer head, then a
  // direct LU bypass when nothing is queued; invalid heads are popped alone.
  always_comb begin
    src        = WB_NONE;
    sel_id     = '0;
    sel_data   = '0;
    fifo_pop   = 1'b0;
    fifo_push  = 1'b0;
    push_entry = '0;

    if (pipe_write) begin
      src      = WB_PIPE;
      sel_id   = wb_rd_id;
      sel_data = pipe_data;
    end else if (!fifo_empty && head.valid) begin
      src      = WB_PEND;
      sel_id   = head.rd;
      sel_data = head.data;
    end else if (fifo_empty && lu_accept && lu_nonzero) begin
      src      = WB_LU_BYPASS;
      sel_id   = lu_rd_id;
      sel_data = lu_data;
    end

    fifo_pop  = !fifo_empty && (!head.valid || !pipe_write);
    fifo_push = lu_accept && lu_nonzero && (pipe_write || !fifo_empty);

    push_entry.valid = !(pipe_write && (lu_rd_id == wb_rd_id));
    push_entry.rd    = lu_rd_id;
    push_entry.data  = lu_data;
  end

  // Register the selected source; id/data hold when nothing is written.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      write_en   <= 1'b0;
      write_id   <= '0;
      write_data <= '0;
    end else begin
      write_en <= (src != WB_NONE);
      if (src != WB_NONE) begin
        write_id   <= sel_id;
        write_data <= sel_data;
      end
    end
  end

`ifdef WB_FORWARD_EN
  assign fwd_valid = !reset && (src != WB_NONE);
  assign fwd_id    = sel_id;
  assign fwd_data  = sel_data;
`endif

endmodule

// File: tb/tb_writeback_stage.sv
// Self-checking bench for writeback_stage: directed vectors push their
// hand-computed register-file writes into a queue; a monitor pops and
// compares every write the DUT presents.
module tb_writeback_stage;

  logic        clk;
  logic        reset;
  logic        wb_valid;
  logic        wb_reg_write;
  logic        wb_mem_read;
  logic [2:0]  wb_funct3;
  logic [4:0]  wb_rd_id;
  logic [31:0] wb_alu_result;
  logic [31:0] wb_mem_data;
  logic        lu_valid;
  logic        lu_ready;
  logic [4:0]  lu_rd_id;
  logic [31:0] lu_data;
  logic        write_en;
  logic [4:0]  write_id;
  logic [31:0] write_data;
  logic [2:0]  pend_count;
`ifdef WB_FORWARD_EN
  logic        fwd_valid;
  logic [4:0]  fwd_id;
  logic [31:0] fwd_data;
`endif

  typedef struct {
    logic [4:0]  id;
    logic [31:0] data;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;

  writeback_stage #(
    .DATA_WIDTH     (32),
    .REG_ADDR_WIDTH (5),
    .PEND_DEPTH     (4)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .wb_valid      (wb_valid),
    .wb_reg_write  (wb_reg_write),
    .wb_mem_read   (wb_mem_read),
    .wb_funct3     (wb_funct3),
    .wb_rd_id      (wb_rd_id),
    .wb_alu_result (wb_alu_result),
    .wb_mem_data   (wb_mem_data),
    .lu_valid      (lu_valid),
    .lu_ready      (lu_ready),
    .lu_rd_id      (lu_rd_id),
    .lu_data       (lu_data),
    .write_en      (write_en),
    .write_id      (write_id),
    .write_data    (write_data),
    .pend_count    (pend_count)
`ifdef WB_FORWARD_EN
    ,
    .fwd_valid     (fwd_valid),
    .fwd_id        (fwd_id),
    .fwd_data      (fwd_data)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %h, required %h", name, actual, expected);
    end
  endtask

  task automatic expectWrite(input logic [4:0] id, input logic [31:0] data);
    exp_t e;
    e.id   = id;
    e.data = data;
    exp_q.push_back(e);
  endtask

  // Drive both sources for one cycle, then step just past the sampling edge.
  task automatic applyStimulus(input logic pv, input logic [4:0] prd,
                               input logic mr, input logic [2:0] f3,
                               input logic [31:0] alu, input logic [31:0] md,
                               input logic lv, input logic [4:0] lrd,
                               input logic [31:0] ld);
    wb_valid      = pv;
    wb_reg_write  = pv;
    wb_mem_read   = mr;
    wb_funct3     = f3;
    wb_rd_id      = prd;
    wb_alu_result = alu;
    wb_mem_data   = md;
    lu_valid      = lv;
    lu_rd_id      = lrd;
    lu_data       = ld;
    @(posedge clk);
    #1;
  endtask

  task automatic idleCycle();
    applyStimulus(1'b0, 5'd0, 1'b0, 3'd0, 32'h0, 32'h0, 1'b0, 5'd0, 32'h0);
  endtask

  // Monitor: every presented write must match the next expected one.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (!reset && write_en) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("[TB] FAIL unexpected_write: got id=%0d data=%h, required no write",
                   write_id, write_data);
        end else begin
          e = exp_q.pop_front();
          if (write_id !== e.id || write_data !== e.data) begin
            errors++;
            $display("[TB] FAIL write_port: got id=%0d data=%h, required id=%0d data=%h",
                     write_id, write_data, e.id, e.data);
          end
        end
      end
    end
  end

  initial begin
    reset = 1'b1;
    wb_valid = 0; wb_reg_write = 0; wb_mem_read = 0; wb_funct3 = 0;
    wb_rd_id = 0; wb_alu_result = 0; wb_mem_data = 0;
    lu_valid = 0; lu_rd_id = 0; lu_data = 0;
    repeat (2) @(posedge clk);
    #1;
    checkOutput("reset_write_en", write_en, 0);
    checkOutput("reset_write_id", write_id, 0);
    checkOutput("reset_write_data", write_data, 0);
    checkOutput("reset_pend_count", pend_count, 0);
    reset = 1'b0;
    @(posedge clk);
    #1;
    checkOutput("lu_ready_after_reset", lu_ready, 1);

    // Load extraction / extension and plain ALU results
    expectWrite(5'd5, 32'hFFFFFFFF);
    applyStimulus(1, 5'd5, 1, 3'b000, 32'h00001002, 32'h80FF7F01, 0, 0, 0);
    expectWrite(5'd6, 32'h000000FF);
    applyStimulus(1, 5'd6, 1, 3'b100, 32'h00001002, 32'h80FF7F01, 0, 0, 0);
    expectWrite(5'd7, 32'hFFFF80FF);
    applyStimulus(1, 5'd7, 1, 3'b001, 32'h00001002, 32'h80FF7F01, 0, 0, 0);
    expectWrite(5'd8, 32'h80FF7F01);
    applyStimulus(1, 5'd8, 1, 3'b010, 32'h00001000, 32'h80FF7F01, 0, 0, 0);
    expectWrite(5'd10, 32'h00007F01);
    applyStimulus(1, 5'd10, 1, 3'b101, 32'h00001000, 32'h80FF7F01, 0, 0, 0);
    expectWrite(5'd12, 32'h00000001);
    applyStimulus(1, 5'd12, 1, 3'b000, 32'h00001000, 32'h80FF7F01, 0, 0, 0);
    expectWrite(5'd11, 32'hDEADBEEF);
    applyStimulus(1, 5'd11, 0, 3'b000, 32'hDEADBEEF, 32'h0, 0, 0, 0);
    idleCycle();

    // Direct LU bypass on an idle port
    expectWrite(5'd7, 32'h00001234);
    applyStimulus(0, 0, 0, 0, 0, 0, 1, 5'd7, 32'h00001234);
    checkOutput("bypass_pend_count", pend_count, 0);
    idleCycle();

    // Back-pressure: pipe busy every cycle while 5 LU results arrive
    for (int i = 0; i < 5; i++) begin
      checkOutput($sformatf("bp_lu_ready_%0d", i), lu_ready, (i < 4) ? 1 : 0);
      expectWrite(5'(20 + i), 32'(100 + i));
      applyStimulus(1, 5'(20 + i), 0, 0, 32'(100 + i), 0, 1, 5'(12 + i), 32'(500 + i));
    end
    checkOutput("bp_pend_full", pend_count, 4);
    for (int i = 0; i < 4; i++) expectWrite(5'(12 + i), 32'(500 + i));
    for (int i = 0; i < 4; i++) begin
      idleCycle();
      checkOutput($sformatf("drain_count_%0d", i), pend_count, 32'(3 - i));
    end
    idleCycle();

    // Pending entry killed by a younger pipe write to the same rd
    expectWrite(5'd3, 32'h00000033);
    applyStimulus(1, 5'd3, 0, 0, 32'h33, 0, 1, 5'd9, 32'h99);
    checkOutput("kill_enqueued", pend_count, 1);
    expectWrite(5'd9, 32'h000000AA);
    applyStimulus(1, 5'd9, 0, 0, 32'hAA, 0, 0, 0, 0);
    checkOutput("kill_still_counted", pend_count, 1);
    idleCycle();
    checkOutput("kill_skipped_pop", pend_count, 0);
    @(negedge clk);
    checkOutput("kill_no_write", write_en, 0);

    // LU result killed in the same cycle it is accepted
    expectWrite(5'd4, 32'h00000044);
    applyStimulus(1, 5'd4, 0, 0, 32'h44, 0, 1, 5'd4, 32'h77);
    checkOutput("same_cycle_kill_count", pend_count, 1);
    idleCycle();
    checkOutput("same_cycle_kill_pop", pend_count, 0);
    @(negedge clk);
    checkOutput("same_cycle_kill_no_write", write_en, 0);

    // rd==0 from both sources is dropped
    applyStimulus(1, 5'd0, 0, 0, 32'h55, 0, 1, 5'd0, 32'h66);
    @(negedge clk);
    checkOutput("rd0_no_write", write_en, 0);
    checkOutput("rd0_pend_count", pend_count, 0);

    // Reset asserted with three entries pending
    @(posedge clk);
    #1;
    for (int i = 0; i < 3; i++) begin
      expectWrite(5'(21 + i), 32'(200 + i));
      applyStimulus(1, 5'(21 + i), 0, 0, 32'(200 + i), 0, 1, 5'(16 + i), 32'(600 + i));
    end
    checkOutput("pre_reset_count", pend_count, 3);
    wb_valid = 0; wb_reg_write = 0; lu_valid = 0;
    @(negedge clk);
    #1;
    reset = 1'b1;
    #1;
    checkOutput("mid_reset_write_en", write_en, 0);
    checkOutput("mid_reset_pend_count", pend_count, 0);
    idleCycle();
    idleCycle();
    reset = 1'b0;
    #1;
    checkOutput("post_reset_lu_ready", lu_ready, 1);
    repeat (6) idleCycle();
    checkOutput("post_reset_pend_count", pend_count, 0);

    checkOutput("scoreboard_empty", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
